// File: rtl/perf_counter_bank.sv
// perf_counter_bank: a bank of independent start/stop cycle counters.
// Each channel can accumulate over several intervals, flag overflow and
// count completed intervals. A global snapshot copies every channel's counter
// and overflow flag into shadow registers in one edge, so the host can read a
// coherent set while the live counters keep running.
//
// Event interface: start/stop/clear/snap are single-cycle pulses sampled on
// the rising clock edge. There is no backpressure. snap_valid is a one-cycle
// pulse in the cycle after the snap edge, and it marks new shadow contents.
module perf_counter_bank #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter int RUNS_W   = 8,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         stop,
  input  logic [NUM_CH-1:0]         accum,
  input  logic [NUM_CH-1:0]         clear,
  input  logic                      snap,
  output logic [NUM_CH*WIDTH-1:0]   value,
  output logic [NUM_CH*RUNS_W-1:0]  runs,
  output logic [NUM_CH-1:0]         running,
  output logic [NUM_CH-1:0]         ovf,
  output logic [NUM_CH*WIDTH-1:0]   snap_value,
  output logic [NUM_CH-1:0]         snap_ovf,
  output logic                      snap_valid
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [RUNS_W-1:0] RUNS_MAX = {RUNS_W{1'b1}};

  state_t              state_q [NUM_CH];
  logic [WIDTH-1:0]    cnt_q   [NUM_CH];
  logic [RUNS_W-1:0]   runs_q  [NUM_CH];
  logic [NUM_CH-1:0]   ovf_q;

  logic [NUM_CH*WIDTH-1:0] snap_value_q;
  logic [NUM_CH-1:0]       snap_ovf_q;
  logic                    snap_valid_q;

  // Per-channel FSM and counters. The priority is clear, then a start from
  // IDLE, then a stop in RUN, then counting in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        runs_q[i]  <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clear[i]) begin
          state_q[i] <= ST_IDLE;
          cnt_q[i]   <= '0;
          runs_q[i]  <= '0;
          ovf_q[i]   <= 1'b0;
        end else if (state_q[i] == ST_IDLE) begin
          // A stop without a start is ignored in IDLE. The start edge itself
          // does not count, so start at edge 0 and stop at edge N gives N-1.
          if (start[i]) begin
            state_q[i] <= ST_RUN;
            if (!accum[i]) begin
              cnt_q[i] <= '0;
              ovf_q[i] <= 1'b0;
            end
          end
        end else if (stop[i]) begin
          // The stop edge holds the count. A start in the same cycle is ignored.
          state_q[i] <= ST_IDLE;
          if (runs_q[i] != RUNS_MAX) begin
            runs_q[i] <= runs_q[i] + 1'b1;
          end
        end else if (cnt_q[i] == CNT_MAX) begin
          // Increment at all-ones: the counter wraps or holds, and ovf is sticky.
          ovf_q[i] <= 1'b1;
          if (SATURATE == 0) begin
            cnt_q[i] <= '0;
          end
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Shadow capture samples the register outputs as they stand before the
  // edge. Because of that, a clear on the same edge leaves the pre-clear
  // value in the shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_value_q <= '0;
      snap_ovf_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= snap;
      if (snap) begin
        snap_value_q <= value;
        snap_ovf_q   <= ovf_q;
      end
    end
  end

  // Flatten the per-channel registers onto the packed output buses.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign value[g*WIDTH +: WIDTH]   = cnt_q[g];
    assign runs[g*RUNS_W +: RUNS_W]  = runs_q[g];
    assign running[g]                = (state_q[g] == ST_RUN);
  end

  assign ovf        = ovf_q;
  assign snap_value = snap_value_q;
  assign snap_ovf   = snap_ovf_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed testbench for perf_counter_bank. The main instance has 4 channels
// of 32 bits. Two single-channel 8-bit instances cover the wrapping and the
// saturating overflow behaviour. Inputs change on the falling edge, and
// outputs are checked on the falling edge or at a fixed offset from it.
module tb_perf_counter_bank;

  logic clk;
  logic rst;

  // main 4x32 instance
  logic [3:0]   start, stop, accum, clear;
  logic         snap;
  logic [127:0] value, snap_value;
  logic [31:0]  runs;
  logic [3:0]   running, ovf, snap_ovf;
  logic         snap_valid;

  // 1x8 instances; a = wrapping, b = saturating
  logic [0:0] start8, stop8, accum8, clear8;
  logic       snap8;
  logic [7:0] v8a, sv8a, v8b, sv8b;
  logic [3:0] r8a, r8b;
  logic [0:0] run8a, ovf8a, so8a, run8b, ovf8b, so8b;
  logic       svld8a, svld8b;

  int n_cmp = 0;
  int n_err = 0;

  perf_counter_bank #(.NUM_CH(4), .WIDTH(32), .RUNS_W(8), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .accum(accum),
    .clear(clear), .snap(snap), .value(value), .runs(runs),
    .running(running), .ovf(ovf), .snap_value(snap_value),
    .snap_ovf(snap_ovf), .snap_valid(snap_valid)
  );

  perf_counter_bank #(.NUM_CH(1), .WIDTH(8), .RUNS_W(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start8), .stop(stop8), .accum(accum8),
    .clear(clear8), .snap(snap8), .value(v8a), .runs(r8a),
    .running(run8a), .ovf(ovf8a), .snap_value(sv8a),
    .snap_ovf(so8a), .snap_valid(svld8a)
  );

  perf_counter_bank #(.NUM_CH(1), .WIDTH(8), .RUNS_W(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start8), .stop(stop8), .accum(accum8),
    .clear(clear8), .snap(snap8), .value(v8b), .runs(r8b),
    .running(run8b), .ovf(ovf8b), .snap_value(sv8b),
    .snap_ovf(so8b), .snap_valid(svld8b)
  );

  // clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_value"},      value,      '0);
    chk({tag, "_runs"},       runs,       '0);
    chk({tag, "_running"},    running,    '0);
    chk({tag, "_ovf"},        ovf,        '0);
    chk({tag, "_snap_value"}, snap_value, '0);
    chk({tag, "_snap_ovf"},   snap_ovf,   '0);
    chk({tag, "_snap_valid"}, snap_valid, '0);
    chk({tag, "_w8_state"}, {v8a, r8a, run8a, ovf8a, sv8a, so8a, svld8a,
                             v8b, r8b, run8b, ovf8b, sv8b, so8b, svld8b}, '0);
  endtask

  initial begin
    rst = 1'b1;
    start = '0; stop = '0; accum = '0; clear = '0; snap = 1'b0;
    start8 = '0; stop8 = '0; accum8 = '0; clear8 = '0; snap8 = 1'b0;
    tick(2);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // basic interval on channel 0: start at edge 0, stop at edge 10 -> 9
    start[0] = 1'b1; tick(1); start[0] = 1'b0;
    chk("basic_running", running, 4'b0001);
    chk("basic_value_e0", value[31:0], 32'd0);
    tick(9);
    chk("basic_value_e9", value[31:0], 32'd9);
    stop[0] = 1'b1; tick(1); stop[0] = 1'b0;
    chk("basic_value_stop", value[31:0], 32'd9);
    chk("basic_idle", running, 4'b0000);
    chk("basic_runs", runs[7:0], 8'd1);
    chk("basic_others_value", value[127:32], 96'd0);
    chk("basic_others_runs", runs[31:8], 24'd0);
    tick(2);
    chk("basic_hold_idle", value[31:0], 32'd9);

    // accumulate on channel 1: 5 counts plus 3 counts
    start[1] = 1'b1; tick(1); start[1] = 1'b0;
    tick(5);
    stop[1] = 1'b1; tick(1); stop[1] = 1'b0;
    chk("acc_first", value[63:32], 32'd5);
    chk("acc_first_runs", runs[15:8], 8'd1);
    accum[1] = 1'b1; start[1] = 1'b1; tick(1); start[1] = 1'b0; accum[1] = 1'b0;
    chk("acc_start_keeps", value[63:32], 32'd5);
    chk("acc_running", running[1], 1'b1);
    tick(3);
    stop[1] = 1'b1; tick(1); stop[1] = 1'b0;
    chk("acc_total", value[63:32], 32'd8);
    chk("acc_runs", runs[15:8], 8'd2);
    start[1] = 1'b1; tick(1); start[1] = 1'b0;
    chk("acc_restart_zero", value[63:32], 32'd0);
    chk("acc_restart_running", running[1], 1'b1);
    stop[1] = 1'b1; tick(1); stop[1] = 1'b0;
    chk("acc_runs3", runs[15:8], 8'd3);

    // simultaneous events on channels 2 and 3
    start[2] = 1'b1; stop[2] = 1'b1; tick(1); start[2] = 1'b0; stop[2] = 1'b0;
    chk("ss_idle_enters_run", running[2], 1'b1);
    chk("ss_idle_runs", runs[23:16], 8'd0);
    tick(2);
    chk("ss_count2", value[95:64], 32'd2);
    start[2] = 1'b1; stop[2] = 1'b1; tick(1); start[2] = 1'b0; stop[2] = 1'b0;
    chk("ss_run_exits", running[2], 1'b0);
    chk("ss_run_value", value[95:64], 32'd2);
    chk("ss_run_runs", runs[23:16], 8'd1);
    stop[3] = 1'b1; tick(1); stop[3] = 1'b0;
    chk("stop_in_idle", {running[3], runs[31:24]}, 9'd0);
    start[2] = 1'b1; tick(1); start[2] = 1'b0;
    tick(3);
    chk("clr_pre", value[95:64], 32'd3);
    clear[2] = 1'b1; start[2] = 1'b1; tick(1); clear[2] = 1'b0; start[2] = 1'b0;
    chk("clr_start_value", value[95:64], 32'd0);
    chk("clr_start_runs", runs[23:16], 8'd0);
    chk("clr_start_running", running, 4'b0000);

    // snapshot coherency with staggered start times
    start[0] = 1'b1; tick(1); start[0] = 1'b0;
    tick(2);
    start[1] = 1'b1; tick(1); start[1] = 1'b0;
    tick(1);
    start[2] = 1'b1; tick(1); start[2] = 1'b0;
    start[3] = 1'b1; tick(1); start[3] = 1'b0;
    tick(1);
    chk("snap_pre_live", value, {32'd1, 32'd2, 32'd4, 32'd7});
    snap = 1'b1; clear[3] = 1'b1; tick(1); clear[3] = 1'b0;
    chk("snap1_valid", snap_valid, 1'b1);
    chk("snap1_value", snap_value, {32'd1, 32'd2, 32'd4, 32'd7});
    chk("snap1_ovf", snap_ovf, 4'b0000);
    chk("snap1_live", value, {32'd0, 32'd3, 32'd5, 32'd8});
    chk("snap1_running", running, 4'b0111);
    tick(1); snap = 1'b0;
    chk("snap2_valid", snap_valid, 1'b1);
    chk("snap2_value", snap_value, {32'd0, 32'd3, 32'd5, 32'd8});
    tick(1);
    chk("snap_valid_drop", snap_valid, 1'b0);
    chk("snap_hold", snap_value, {32'd0, 32'd3, 32'd5, 32'd8});
    chk("snap_live_after", value, {32'd0, 32'd5, 32'd7, 32'd10});
    chk("runs_vector", runs, {8'd0, 8'd0, 8'd3, 8'd1});

    // overflow on the 8-bit instances: 300-edge interval
    start8 = 1'b1; tick(1); start8 = 1'b0;
    tick(299);
    chk("ovf_wrap_value", v8a, 8'd43);
    chk("ovf_wrap_flag", ovf8a, 1'b1);
    chk("ovf_sat_value", v8b, 8'd255);
    chk("ovf_sat_flag", ovf8b, 1'b1);
    stop8 = 1'b1; tick(1); stop8 = 1'b0;
    chk("ovf_stop_values", {v8a, v8b}, {8'd43, 8'd255});
    chk("ovf_stop_idle", {run8a, run8b}, 2'b00);
    chk("ovf_stop_runs", {r8a, r8b}, {4'd1, 4'd1});
    accum8 = 1'b1; start8 = 1'b1; tick(1); start8 = 1'b0; accum8 = 1'b0;
    chk("ovf_acc_keep", {v8a, ovf8a, v8b, ovf8b}, {8'd43, 1'b1, 8'd255, 1'b1});
    tick(1);
    stop8 = 1'b1; tick(1); stop8 = 1'b0;
    chk("ovf_acc_count", {v8a, v8b}, {8'd44, 8'd255});
    snap8 = 1'b1; tick(1); snap8 = 1'b0;
    chk("ovf_snap", {sv8a, so8a, svld8a, sv8b, so8b, svld8b},
        {8'd44, 1'b1, 1'b1, 8'd255, 1'b1, 1'b1});
    start8 = 1'b1; tick(1); start8 = 1'b0;
    chk("ovf_restart_clears", {v8a, ovf8a, v8b, ovf8b}, 18'd0);

    // reset mid-run: all channels running, 8-bit instances overflowed
    start[3] = 1'b1; tick(1); start[3] = 1'b0;
    tick(260);
    chk("mid_running", running, 4'b1111);
    chk("mid_w8", {v8a, ovf8a, run8a, ovf8b, run8b}, {8'd5, 1'b1, 1'b1, 1'b1, 1'b1});
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    tick(1);
    rst = 1'b0;
    tick(3);
    chk("post_rst_idle", {running, run8a, run8b}, 6'd0);
    chk("post_rst_value", value, '0);
    start[0] = 1'b1; tick(1); start[0] = 1'b0;
    tick(2);
    chk("post_rst_restart", {running, value[31:0]}, {4'b0001, 32'd2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Multi-channel, parametrised cycle counter bank for emulation-shell performance measurement. Each channel measures the cycles between a start event and a stop event. Channels can also accumulate across several intervals, flag overflow, and count completed intervals. A global snapshot captures all channels coherently into shadow registers for host readout while counting continues.

Parameters:
NUM_CH, 4, number of independent counter channels (1..32)
WIDTH, 32, counter width in bits (8..64)
RUNS_W, 8, width of per-channel completed-interval counter
SATURATE, 0, 0 = counter wraps at all-ones, 1 = counter holds at all-ones

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  NUM_CH  per-channel start pulse
stop  in  NUM_CH  per-channel stop pulse
accum  in  NUM_CH  per-channel accumulate select, sampled with start
clear  in  NUM_CH  per-channel synchronous clear
snap  in  1  global snapshot request pulse
value  out  NUM_CH*WIDTH  live counters, channel i at [i*WIDTH +: WIDTH]
runs  out  NUM_CH*RUNS_W  completed-interval counts, channel i at [i*RUNS_W +: RUNS_W]
running  out  NUM_CH  channel i is in RUN
ovf  out  NUM_CH  sticky overflow flag per channel
snap_value  out  NUM_CH*WIDTH  shadow copy of value captured by snap
snap_ovf  out  NUM_CH  shadow copy of ovf captured by snap
snap_valid  out  1  one-cycle pulse when shadow registers update

Behaviour:
- Reset (async): all counters 0, runs 0, running 0, ovf 0, snap_value 0, snap_ovf 0, snap_valid 0. Every channel goes to IDLE.
- Per-channel FSM with two states, IDLE (running=0) and RUN (running=1). Channels are fully independent.
- Per-channel priority, highest first: clear, then IDLE&start, then RUN&stop, then RUN.
- clear: at the next edge the counter, runs and ovf go to 0 and the channel goes to IDLE, regardless of start, stop or state.
- IDLE & start: the channel goes to RUN. The counter is loaded with 0 if accum=0, or keeps its value if accum=1. ovf is cleared only when accum=0. The counter does not increment on this edge.
- IDLE & stop with no start: ignored.
- RUN, no stop: the counter increments by 1 on every edge. start is ignored while in RUN.
- RUN & stop (start may also be asserted): the channel goes to IDLE. The counter holds without incrementing on this edge. runs increments by 1 and saturates at 2^RUNS_W-1.
- Resulting count: start sampled at edge 0 and stop sampled at edge N gives value = N-1.
- Overflow: applies when an increment occurs at all-ones.
  - SATURATE=0: the counter wraps to 0 and ovf is set.
  - SATURATE=1: the counter holds all-ones and ovf is set.
  - ovf is sticky until clear or a non-accumulating start.
- value, runs, running and ovf are driven directly from registers. There is no combinational input-to-output path.
- snap: at the edge where snap is sampled, snap_value and snap_ovf load the register values as they are before that edge. snap_valid is 1 during the following cycle only. Shadow registers hold between snaps.
- Snapshot capture does not disturb counting.
- clear and snap on the same edge: the shadow gets the pre-clear value.
- Back-to-back snap pulses give snap_valid high on consecutive cycles.
- Width rules:
  - All counter arithmetic is modulo 2^WIDTH, except the saturation described above.
  - runs never wraps.
  - The channel index maps to the bit slice exactly as listed in Ports.

Test Plan:
- Basic interval (NUM_CH=4, WIDTH=32): start[0] at edge 0, stop[0] at edge 10 -> value[0]=9, running[0]=0 from edge 10, runs[0]=1. Other channels stay 0.
- Accumulate: channel 1 interval of 5 counts, then start with accum=1 and a second interval of 3 counts -> value=8, runs=2. A later start with accum=0 -> value 0, ovf cleared.
- Overflow with WIDTH=8: run 300 cycles.
  - SATURATE=0 -> value=(299 mod 256)=43, ovf=1.
  - SATURATE=1 -> value=255, ovf=1.
- Simultaneous events:
  - start&stop in IDLE -> enters RUN.
  - start&stop in RUN -> exits to IDLE, runs+1.
  - clear with start in the same cycle -> IDLE, value 0.
- Snapshot coherency: channels 0..3 running with different start times; snap at edge T -> snap_value equals each value at T-1, snap_valid high one cycle, live counters keep incrementing.
- Reset mid-run: assert rst asynchronously while all channels are in RUN with ovf set -> all outputs 0 immediately. After release, the channels remain IDLE until the next start.
